dma_channel_sequencer: RTL and testbench
========================================

Name: dma_channel_sequencer

Overview:
Timing-and-control plus priority block for the 4-channel DMA. It arbitrates DREQ lines and runs the HRQ/HLDA bus handshake. It sequences each word transfer by driving the datapath control strobes (loadAddr, address inc/dec, word-count decrement, current-register update, intEOP) and the system bus strobes. It also produces programCondition, which gates register programming in the datapath.

Parameters:
CHANNELS, 4, number of DMA channels (DREQ/DACK width)
MODEWIDTH, 6, width of one per-channel mode register entry (DATAWIDTH-2)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
CS_N  input  1  chip select from CPU
HLDA  input  1  hold acknowledge from CPU
DREQ  input  CHANNELS  channel requests, active high
EOP_N_IN  input  1  external end-of-process, active low
commandReg  input  8  bit2 = controller disable; bit4 = rotating priority
modeReg  input  CHANNELS x MODEWIDTH  [5:4] mode (00 demand, 01 single, 10 block, 11 reserved=single); [3] address decrement; [2] autoinit; [1:0] transfer (01 write-to-mem, 10 read-from-mem, 00 verify)
wordCountZero  input  1  datapath temporaryWordCountReg == 0
HRQ  output  1  hold request
DACK  output  CHANNELS  one-hot acknowledge
AEN, ADSTB  output  1 each  address enable, address strobe
MEMR_N, MEMW_N, IOR_N, IOW_N  output  1 each  bus strobes, active low
EOP_N_OUT  output  1  terminal-count pulse, active low
programCondition  output  1  register programming allowed
loadAddr, incrTemporaryAddressReg, decrTemporaryAddressReg, decrTemporaryWordCountReg  output  1 each  datapath strobes
updateCurrentAddressReg, updateCurrentWordCountReg, autoInitReload, intEOP  output  1 each  datapath strobes
activeChannel  output  2  latched channel under service

Behaviour:
- Reset: state SI. HRQ, DACK, AEN, ADSTB and all datapath strobes = 0. All _N strobes and EOP_N_OUT = 1. activeChannel = 0. Priority pointer = ch0 highest. A reset in any state aborts with no datapath updates.
- programCondition = !CS_N & !HLDA & (state==SI). It is combinational.
- Priority: fixed means ch0 highest to ch3 lowest. Rotating means the channel just serviced becomes lowest; the pointer updates when the channel leaves SU.
- SI: if commandReg[2]==0 and |DREQ, latch the winner into activeChannel and go to S0. Otherwise stay.
- S0: HRQ=1. On HLDA go to S1. If DREQ[activeChannel] drops before HLDA, go to SI and drop HRQ.
- S1: AEN=1, DACK[ch]=1, ADSTB=1, loadAddr=1. Go to S2.
- S2: read strobe asserted. Write transfer uses IOR_N=0; read transfer uses MEMR_N=0; verify asserts none. Go to S3.
- S3: read strobe held, plus write strobe (MEMW_N for write, IOW_N for read). Go to S4.
- S4: strobes held. Pulse decrTemporaryWordCountReg. Pulse incr or decr TemporaryAddressReg per modeReg[3]. Sample tc = wordCountZero and ext = !EOP_N_IN. Go to SU.
- SU: strobes deasserted. Pulse updateCurrentAddressReg and updateCurrentWordCountReg (DACK still held).
  - If tc or ext: intEOP=1. EOP_N_OUT=0 only if tc. autoInitReload=1 if modeReg[2]. Go to SI.
  - Else single mode: go to SI; HRQ low at least one cycle.
  - Else block mode: go to S1.
  - Else demand mode: go to S1 if DREQ[ch] is high, otherwise SI.
- AEN and DACK hold from S1 through SU. HRQ holds from S0 through SU.
- HLDA low in S1..S4: abort to SI next cycle. No update or EOP pulses are issued.
- DREQ drop in S1..S4: the current word completes; the decision is taken in SU.
- EOP_N_IN asserted in S2..S4 is captured (sticky) and acted on in SU.
- Every pulse output is exactly one cycle wide.

Decomposition:
- dmaRegConfigPkg holds:
  - enum state_t {SI,S0,S1,S2,S3,S4,SU};
  - enum modeType_t;
  - enum transferType_t;
  - constants CMD_DISABLE_BIT=2 and CMD_ROTATE_BIT=4;
  - the existing CHANNELS/DATAWIDTH.
- One sub-module, dma_priority_encoder, is natural. It is combinational, taking DREQ, the rotate enable and the pointer, and producing grant index and valid.

Test Plan:
- DREQ=4'b0001, single, write, count=0, HLDA one cycle after HRQ:
  - HRQ at cycle 1, DACK=0001 at S1.
  - IOR_N low in S2..S4; MEMW_N low in S3..S4.
  - Then EOP_N_OUT, intEOP and the update pulses in SU, then back to SI.
- Block mode ch2, count=2: exactly 3 S1..SU loops, one EOP_N_OUT pulse after the third, autoInitReload=1 when modeReg[2]=1.
- DREQ=4'b1010 with fixed priority serves ch1 first. With rotating priority, after serving ch1 a held DREQ=4'b1010 next grants ch3.
- Demand mode ch0:
  - DREQ dropped during S3: the word completes, then SI.
  - EOP_N_IN pulsed in S2: intEOP=1 while EOP_N_OUT stays 1.
- HLDA deasserted in S2: SI next cycle, strobes high, no update pulses. RESET in S3: all outputs at reset values on the next cycle.
- commandReg[2]=1 with DREQ=4'hF: HRQ stays 0. With CS_N=0 and HLDA=0, programCondition=1.

Source files
------------

// File: rtl/dma_channel_sequencer_pkg.sv
// Shared types and constants for the DMA channel sequencer: FSM states,
// mode/transfer decodes, command-register bit positions and the registered
// output bundle driven by the sequencer FSM.
package dma_channel_sequencer_pkg;

   localparam int CHANNELS  = 4;
   localparam int DATAWIDTH = 8;
   localparam int MODEWIDTH = DATAWIDTH - 2;
   localparam int CH_W      = $clog2(CHANNELS);

   localparam int CMD_DISABLE_BIT = 2;
   localparam int CMD_ROTATE_BIT  = 4;

   typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4, SU} state_t;

   typedef enum logic [1:0] {
      MODE_DEMAND = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_BLOCK  = 2'b10,
      MODE_RSVD   = 2'b11
   } modeType_t;

   typedef enum logic [1:0] {
      XFER_VERIFY  = 2'b00,
      XFER_WRITE   = 2'b01,
      XFER_READ    = 2'b10,
      XFER_ILLEGAL = 2'b11
   } transferType_t;

   // Every sequencer output lives in one registered bundle.
   typedef struct packed {
      logic                hrq;
      logic [CHANNELS-1:0] dack;
      logic                aen;
      logic                adstb;
      logic                memr_n;
      logic                memw_n;
      logic                ior_n;
      logic                iow_n;
      logic                eop_n_out;
      logic                load_addr;
      logic                incr_addr;
      logic                decr_addr;
      logic                decr_wc;
      logic                upd_addr;
      logic                upd_wc;
      logic                auto_init;
      logic                int_eop;
   } seq_out_t;

   // Idle bus: nothing requested, every active-low strobe released.
   function automatic seq_out_t out_idle();
      seq_out_t o;
      o           = '0;
      o.memr_n    = 1'b1;
      o.memw_n    = 1'b1;
      o.ior_n     = 1'b1;
      o.iow_n     = 1'b1;
      o.eop_n_out = 1'b1;
      return o;
   endfunction

endpackage

// File: rtl/dma_channel_sequencer_if.sv
// Signal bundle between the sequencer and its surroundings (CPU handshake,
// channel requests, system bus strobes and datapath control strobes).
// Handshake: a channel requests with DREQ and holds it; the sequencer raises
// HRQ and waits for HLDA, then owns the bus and answers with a one-hot DACK
// for as long as the word (or burst) is in progress.
interface dma_channel_sequencer_if;

   // inputs to the sequencer
   logic                                   CS_N;
   logic                                   HLDA;
   logic [dma_channel_sequencer_pkg::CHANNELS-1:0] DREQ;
   logic                                   EOP_N_IN;
   logic [7:0]                             commandReg;
   logic [dma_channel_sequencer_pkg::CHANNELS-1:0][dma_channel_sequencer_pkg::MODEWIDTH-1:0] modeReg;
   logic                                   wordCountZero;

   // outputs from the sequencer
   logic                                   HRQ;
   logic [dma_channel_sequencer_pkg::CHANNELS-1:0] DACK;
   logic                                   AEN;
   logic                                   ADSTB;
   logic                                   MEMR_N;
   logic                                   MEMW_N;
   logic                                   IOR_N;
   logic                                   IOW_N;
   logic                                   EOP_N_OUT;
   logic                                   programCondition;
   logic                                   loadAddr;
   logic                                   incrTemporaryAddressReg;
   logic                                   decrTemporaryAddressReg;
   logic                                   decrTemporaryWordCountReg;
   logic                                   updateCurrentAddressReg;
   logic                                   updateCurrentWordCountReg;
   logic                                   autoInitReload;
   logic                                   intEOP;
   logic [dma_channel_sequencer_pkg::CH_W-1:0] activeChannel;

   modport slave (
      input  CS_N, HLDA, DREQ, EOP_N_IN, commandReg, modeReg, wordCountZero,
      output HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT,
             programCondition, loadAddr, incrTemporaryAddressReg,
             decrTemporaryAddressReg, decrTemporaryWordCountReg,
             updateCurrentAddressReg, updateCurrentWordCountReg,
             autoInitReload, intEOP, activeChannel
   );

   modport master (
      output CS_N, HLDA, DREQ, EOP_N_IN, commandReg, modeReg, wordCountZero,
      input  HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT,
             programCondition, loadAddr, incrTemporaryAddressReg,
             decrTemporaryAddressReg, decrTemporaryWordCountReg,
             updateCurrentAddressReg, updateCurrentWordCountReg,
             autoInitReload, intEOP, activeChannel
   );

endinterface

// File: rtl/dma_channel_sequencer_priority_encoder.sv
// Combinational DREQ arbiter. Fixed priority: ch0 highest. Rotating
// priority: search starts at the pointer, which the sequencer sets to the
// channel after the one just serviced, so that channel becomes lowest.
module dma_priority_encoder
   import dma_channel_sequencer_pkg::*;
(
   input  logic [CHANNELS-1:0] dreq_i,
   input  logic                rotate_i,
   input  logic [CH_W-1:0]     ptr_i,
   output logic [CH_W-1:0]     grant_o,
   output logic                valid_o
);

   logic [CH_W-1:0] base;
   logic [CH_W-1:0] idx;

   // First requesting channel at or after the search base, wrapping around.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      base    = rotate_i ? ptr_i : '0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = base + CH_W'(i);
         if (!valid_o && dreq_i[idx]) begin
            grant_o = idx;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_channel_sequencer.sv
// Timing-and-control for the 4-channel DMA: arbitrates DREQ, runs the
// HRQ/HLDA handshake and steps each word transfer through S1..SU, driving
// the bus strobes and the datapath update strobes. Every output is a
// register loaded on the edge that enters the state it belongs to, except
// programCondition which is combinational.
module dma_channel_sequencer
   import dma_channel_sequencer_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RESET,
   dma_channel_sequencer_if.slave  bus,
   output state_t                  dbg_state_o
);

   state_t            state_q;
   logic [CH_W-1:0]   active_q;
   logic [CH_W-1:0]   ptr_q;
   logic              ext_q;    // sticky external EOP seen during S2..S4
   logic              term_q;   // word ended on terminal count or external EOP
   seq_out_t          out_q;

   logic [CH_W-1:0]      grant_idx;
   logic                 grant_valid;
   logic [MODEWIDTH-1:0] mode_act;
   modeType_t            mode_type;
   transferType_t        xfer;
   logic [CHANNELS-1:0]  ch_onehot;
   logic                 dreq_act;
   logic                 ext_now;
   logic                 unused_cmd;

   assign mode_act   = bus.modeReg[active_q];
   assign mode_type  = modeType_t'(mode_act[5:4]);
   assign xfer       = transferType_t'(mode_act[1:0]);
   assign ch_onehot  = CHANNELS'(1) << active_q;
   assign dreq_act   = bus.DREQ[active_q];
   assign ext_now    = ext_q | ~bus.EOP_N_IN;
   assign unused_cmd = ^{bus.commandReg[7:5], bus.commandReg[3], bus.commandReg[1:0]};

   dma_priority_encoder u_prio (
      .dreq_i   (bus.DREQ),
      .rotate_i (bus.commandReg[CMD_ROTATE_BIT]),
      .ptr_i    (ptr_q),
      .grant_o  (grant_idx),
      .valid_o  (grant_valid)
   );

   // Sequencer FSM: next state plus the registered outputs of that state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= SI;
         active_q <= '0;
         ptr_q    <= '0;
         ext_q    <= 1'b0;
         term_q   <= 1'b0;
         out_q    <= out_idle();
      end else begin
         // single-cycle pulses fall back unless a branch re-asserts them
         out_q.adstb     <= 1'b0;
         out_q.load_addr <= 1'b0;
         out_q.incr_addr <= 1'b0;
         out_q.decr_addr <= 1'b0;
         out_q.decr_wc   <= 1'b0;
         out_q.upd_addr  <= 1'b0;
         out_q.upd_wc    <= 1'b0;
         out_q.auto_init <= 1'b0;
         out_q.int_eop   <= 1'b0;
         out_q.eop_n_out <= 1'b1;
         case (state_q)
            SI: begin
               if (!bus.commandReg[CMD_DISABLE_BIT] && grant_valid) begin
                  state_q   <= S0;
                  active_q  <= grant_idx;
                  out_q.hrq <= 1'b1;
               end
            end
            S0: begin
               if (bus.HLDA) begin
                  state_q         <= S1;
                  ext_q           <= 1'b0;
                  out_q.aen       <= 1'b1;
                  out_q.dack      <= ch_onehot;
                  out_q.adstb     <= 1'b1;
                  out_q.load_addr <= 1'b1;
               end else if (!dreq_act) begin
                  state_q <= SI;
                  out_q   <= out_idle();
               end
            end
            S1: begin
               if (!bus.HLDA) begin
                  state_q <= SI;
                  out_q   <= out_idle();
               end else begin
                  state_q      <= S2;
                  out_q.memr_n <= ~(xfer == XFER_READ);
                  out_q.ior_n  <= ~(xfer == XFER_WRITE);
               end
            end
            S2: begin
               if (!bus.HLDA) begin
                  state_q <= SI;
                  out_q   <= out_idle();
               end else begin
                  state_q      <= S3;
                  ext_q        <= ext_now;
                  out_q.memw_n <= ~(xfer == XFER_WRITE);
                  out_q.iow_n  <= ~(xfer == XFER_READ);
               end
            end
            S3: begin
               if (!bus.HLDA) begin
                  state_q <= SI;
                  out_q   <= out_idle();
               end else begin
                  state_q         <= S4;
                  ext_q           <= ext_now;
                  out_q.decr_wc   <= 1'b1;
                  out_q.incr_addr <= ~mode_act[3];
                  out_q.decr_addr <= mode_act[3];
               end
            end
            S4: begin
               if (!bus.HLDA) begin
                  state_q <= SI;
                  out_q   <= out_idle();
               end else begin
                  // terminal count and external EOP are decided here so the
                  // SU pulses can be registered on entry to SU
                  state_q         <= SU;
                  term_q          <= bus.wordCountZero | ext_now;
                  out_q.memr_n    <= 1'b1;
                  out_q.memw_n    <= 1'b1;
                  out_q.ior_n     <= 1'b1;
                  out_q.iow_n     <= 1'b1;
                  out_q.upd_addr  <= 1'b1;
                  out_q.upd_wc    <= 1'b1;
                  out_q.int_eop   <= bus.wordCountZero | ext_now;
                  out_q.eop_n_out <= ~bus.wordCountZero;
                  out_q.auto_init <= (bus.wordCountZero | ext_now) & mode_act[2];
               end
            end
            SU: begin
               ptr_q <= active_q + 1'b1;
               if (term_q || mode_type == MODE_SINGLE || mode_type == MODE_RSVD ||
                   (mode_type == MODE_DEMAND && !dreq_act)) begin
                  state_q <= SI;
                  out_q   <= out_idle();
               end else begin
                  // block, or demand with the request still present
                  state_q         <= S1;
                  ext_q           <= 1'b0;
                  out_q.adstb     <= 1'b1;
                  out_q.load_addr <= 1'b1;
               end
            end
            default: begin
               state_q <= SI;
               out_q   <= out_idle();
            end
         endcase
      end
   end

   assign bus.HRQ                       = out_q.hrq;
   assign bus.DACK                      = out_q.dack;
   assign bus.AEN                       = out_q.aen;
   assign bus.ADSTB                     = out_q.adstb;
   assign bus.MEMR_N                    = out_q.memr_n;
   assign bus.MEMW_N                    = out_q.memw_n;
   assign bus.IOR_N                     = out_q.ior_n;
   assign bus.IOW_N                     = out_q.iow_n;
   assign bus.EOP_N_OUT                 = out_q.eop_n_out;
   assign bus.loadAddr                  = out_q.load_addr;
   assign bus.incrTemporaryAddressReg   = out_q.incr_addr;
   assign bus.decrTemporaryAddressReg   = out_q.decr_addr;
   assign bus.decrTemporaryWordCountReg = out_q.decr_wc;
   assign bus.updateCurrentAddressReg   = out_q.upd_addr;
   assign bus.updateCurrentWordCountReg = out_q.upd_wc;
   assign bus.autoInitReload            = out_q.auto_init;
   assign bus.intEOP                    = out_q.int_eop;
   assign bus.activeChannel             = active_q;
   assign bus.programCondition          = ~bus.CS_N & ~bus.HLDA & (state_q == SI);
   assign dbg_state_o                   = state_q;

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Directed bench for the DMA channel sequencer. Per-cycle checks follow the
// state walk; every completed word (SU update pulse) is popped from an
// expected queue filled when its transfer is set up.
module tb_dma_channel_sequencer;
   import dma_channel_sequencer_pkg::*;

   logic   CLK;
   logic   RESET;
   state_t dbg_state;
   int     wc;
   int     n_checks;
   int     n_pass;
   logic [7:0] exp_q[$];

   dma_channel_sequencer_if bus();

   dma_channel_sequencer dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // word-count model: zero flag follows the count, which drops on each SU update
   assign bus.wordCountZero = (wc == 0);

   // clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_state(input string tag, input state_t s, input int max_cycles);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (dbg_state != s && n < max_cycles);
      chk(tag, 16'(dbg_state), 16'(s));
   endtask

   function automatic logic [4:0] strobes();
      return {bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.EOP_N_OUT};
   endfunction

   function automatic logic [8:0] pulses();
      return {bus.ADSTB, bus.loadAddr, bus.incrTemporaryAddressReg,
              bus.decrTemporaryAddressReg, bus.decrTemporaryWordCountReg,
              bus.updateCurrentAddressReg, bus.updateCurrentWordCountReg,
              bus.autoInitReload, bus.intEOP};
   endfunction

   // scoreboard: one record per completed word {DACK, intEOP, EOP_N_OUT, autoInit, updWC}
   initial begin
      logic [7:0] obs;
      logic [7:0] exp;
      forever begin
         @(negedge CLK);
         if (bus.updateCurrentAddressReg === 1'b1) begin
            obs = {bus.DACK, bus.intEOP, bus.EOP_N_OUT, bus.autoInitReload,
                   bus.updateCurrentWordCountReg};
            chk("sb_word_expected", 16'(exp_q.size() != 0), 16'(1));
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               chk("sb_word", 16'(obs), 16'(exp));
            end
            wc = wc - 1;
         end
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      wc       = 0;
      RESET    = 1'b1;
      bus.CS_N = 1'b1;
      bus.HLDA = 1'b0;
      bus.DREQ = '0;
      bus.EOP_N_IN   = 1'b1;
      bus.commandReg = 8'h00;
      bus.modeReg    = '0;
      tick();
      tick();

      // reset values
      chk("rst_state",   16'(dbg_state), 16'(SI));
      chk("rst_hrq",     16'({bus.HRQ, bus.AEN}), 16'(0));
      chk("rst_dack",    16'(bus.DACK), 16'(0));
      chk("rst_strobes", 16'(strobes()), 16'(5'b11111));
      chk("rst_pulses",  16'(pulses()), 16'(0));
      chk("rst_active",  16'(bus.activeChannel), 16'(0));
      chk("rst_progcond_csn1", 16'(bus.programCondition), 16'(0));

      // single-mode write, ch0, terminal count on the only word
      RESET = 1'b0;
      bus.modeReg[0] = 6'b01_0_0_01;
      wc = 0;
      bus.DREQ = 4'b0001;
      tick();
      chk("a_s0_state", 16'(dbg_state), 16'(S0));
      chk("a_s0_hrq",   16'(bus.HRQ), 16'(1));
      bus.HLDA = 1'b1;
      tick();
      chk("a_s1_dack",    16'({bus.AEN, bus.DACK}), 16'(5'b1_0001));
      chk("a_s1_pulses",  16'(pulses()), 16'(9'b110000000));
      chk("a_s1_strobes", 16'(strobes()), 16'(5'b11111));
      tick();
      chk("a_s2_strobes", 16'(strobes()), 16'(5'b11011));
      chk("a_s2_pulses",  16'(pulses()), 16'(0));
      exp_q.push_back({4'b0001, 1'b1, 1'b0, 1'b0, 1'b1});
      tick();
      chk("a_s3_strobes", 16'(strobes()), 16'(5'b10011));
      tick();
      chk("a_s4_strobes", 16'(strobes()), 16'(5'b10011));
      chk("a_s4_pulses",  16'(pulses()), 16'(9'b001010000));
      tick();
      chk("a_su_state",   16'(dbg_state), 16'(SU));
      chk("a_su_strobes", 16'(strobes()), 16'(5'b11110));
      chk("a_su_pulses",  16'(pulses()), 16'(9'b000001101));
      chk("a_su_hold",    16'({bus.HRQ, bus.AEN, bus.DACK}), 16'(6'b11_0001));
      bus.DREQ = '0;
      bus.HLDA = 1'b0;
      tick();
      chk("a_si_state", 16'(dbg_state), 16'(SI));
      chk("a_si_idle",  16'({bus.HRQ, bus.AEN, bus.DACK, strobes()}), 16'(11'b00_0000_11111));

      // block-mode read, ch2, address decrement, autoinit, count 2 -> 3 words
      bus.modeReg[2] = 6'b10_1_1_10;
      wc = 2;
      bus.DREQ = 4'b0100;
      exp_q.push_back({4'b0100, 1'b0, 1'b1, 1'b0, 1'b1});
      exp_q.push_back({4'b0100, 1'b0, 1'b1, 1'b0, 1'b1});
      exp_q.push_back({4'b0100, 1'b1, 1'b0, 1'b1, 1'b1});
      tick();
      chk("b_active", 16'(bus.activeChannel), 16'(2));
      bus.HLDA = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_state("b_reach_s2", S2, 8);
         chk("b_s2_strobes", 16'(strobes()), 16'(5'b01111));
         tick();
         chk("b_s3_strobes", 16'(strobes()), 16'(5'b01101));
         tick();
         chk("b_s4_pulses",  16'(pulses()), 16'(9'b000110000));
         wait_state("b_reach_su", SU, 2);
      end
      bus.DREQ = '0;
      bus.HLDA = 1'b0;
      tick();
      chk("b_done_state", 16'(dbg_state), 16'(SI));
      chk("b_done_hrq",   16'(bus.HRQ), 16'(0));

      // fixed priority with DREQ 1010 serves ch1
      bus.modeReg[1] = 6'b01_0_0_01;
      bus.modeReg[3] = 6'b01_0_0_01;
      wc = 0;
      bus.DREQ = 4'b1010;
      tick();
      chk("c_fixed_grant", 16'(bus.activeChannel), 16'(1));
      bus.HLDA = 1'b1;
      exp_q.push_back({4'b0010, 1'b1, 1'b0, 1'b0, 1'b1});
      wait_state("c_ch1_su", SU, 8);
      bus.HLDA = 1'b0;
      tick();
      chk("c_single_drop_hrq", 16'({bus.HRQ, 3'(dbg_state)}), 16'({1'b0, 3'(SI)}));
      tick();
      chk("c_fixed_regrant", 16'(bus.activeChannel), 16'(1));
      bus.DREQ = '0;
      tick();
      chk("c_s0_dreq_drop", 16'({bus.HRQ, 3'(dbg_state)}), 16'({1'b0, 3'(SI)}));
      // rotating priority: ch1 was last served, so ch3 wins
      bus.commandReg = 8'h10;
      bus.DREQ = 4'b1010;
      wc = 0;
      tick();
      chk("c_rotate_grant", 16'(bus.activeChannel), 16'(3));
      bus.HLDA = 1'b1;
      exp_q.push_back({4'b1000, 1'b1, 1'b0, 1'b0, 1'b1});
      wait_state("c_ch3_su", SU, 8);
      bus.DREQ = '0;
      bus.HLDA = 1'b0;
      bus.commandReg = 8'h00;
      tick();

      // demand write ch0, DREQ dropped during S3
      bus.modeReg[0] = 6'b00_0_0_01;
      wc = 5;
      bus.DREQ = 4'b0001;
      tick();
      bus.HLDA = 1'b1;
      wait_state("d_reach_s3", S3, 8);
      bus.DREQ = '0;
      exp_q.push_back({4'b0001, 1'b0, 1'b1, 1'b0, 1'b1});
      tick();
      chk("d_s4_state", 16'(dbg_state), 16'(S4));
      tick();
      chk("d_su_strobes", 16'(strobes()), 16'(5'b11111));
      tick();
      chk("d_end_state", 16'(dbg_state), 16'(SI));
      bus.HLDA = 1'b0;

      // demand ch0: held DREQ loops, then external EOP in S2 ends it
      wc = 5;
      bus.DREQ = 4'b0001;
      exp_q.push_back({4'b0001, 1'b0, 1'b1, 1'b0, 1'b1});
      exp_q.push_back({4'b0001, 1'b1, 1'b1, 1'b0, 1'b1});
      tick();
      bus.HLDA = 1'b1;
      wait_state("e_w1_su", SU, 8);
      tick();
      chk("e_demand_loop", 16'(dbg_state), 16'(S1));
      wait_state("e_w2_s2", S2, 4);
      bus.EOP_N_IN = 1'b0;
      tick();
      bus.EOP_N_IN = 1'b1;
      wait_state("e_w2_su", SU, 4);
      chk("e_su_strobes", 16'(strobes()), 16'(5'b11111));
      chk("e_su_pulses",  16'(pulses()), 16'(9'b000001101));
      tick();
      chk("e_end_state", 16'(dbg_state), 16'(SI));
      bus.DREQ = '0;
      bus.HLDA = 1'b0;
      tick();

      // HLDA lost in S2: abort, no updates
      bus.modeReg[0] = 6'b01_0_0_01;
      wc = 0;
      bus.DREQ = 4'b0001;
      tick();
      bus.HLDA = 1'b1;
      wait_state("f_reach_s2", S2, 8);
      bus.HLDA = 1'b0;
      bus.DREQ = '0;
      tick();
      chk("f_abort_state",  16'(dbg_state), 16'(SI));
      chk("f_abort_bus",    16'({bus.HRQ, bus.AEN, bus.DACK, strobes()}), 16'(11'b00_0000_11111));
      chk("f_abort_pulses", 16'(pulses()), 16'(0));
      tick();
      tick();

      // RESET in S3
      bus.modeReg[2] = 6'b01_0_0_01;
      bus.DREQ = 4'b0100;
      tick();
      bus.HLDA = 1'b1;
      wait_state("g_reach_s3", S3, 8);
      RESET = 1'b1;
      tick();
      chk("g_rst_state",  16'(dbg_state), 16'(SI));
      chk("g_rst_bus",    16'({bus.HRQ, bus.AEN, bus.DACK, strobes()}), 16'(11'b00_0000_11111));
      chk("g_rst_pulses", 16'(pulses()), 16'(0));
      chk("g_rst_active", 16'(bus.activeChannel), 16'(0));
      RESET = 1'b0;
      bus.DREQ = '0;
      bus.HLDA = 1'b0;
      tick();

      // controller disabled: no HRQ; programming window
      bus.commandReg = 8'h04;
      bus.DREQ = 4'hF;
      tick();
      tick();
      tick();
      chk("h_disabled_hrq",   16'(bus.HRQ), 16'(0));
      chk("h_disabled_state", 16'(dbg_state), 16'(SI));
      bus.CS_N = 1'b0;
      #1;
      chk("h_progcond_on", 16'(bus.programCondition), 16'(1));
      bus.HLDA = 1'b1;
      #1;
      chk("h_progcond_hlda", 16'(bus.programCondition), 16'(0));
      bus.HLDA = 1'b0;
      bus.CS_N = 1'b1;
      bus.DREQ = '0;
      bus.commandReg = 8'h00;

      tick();
      tick();
      chk("sb_drain", 16'(exp_q.size()), 16'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
